// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter that funnels NUM_REQ requesters into one FIFO.
// Define FIFO_WR_ARB_LOCK_EN to add MAX_BURST-push lock tenure per grantee.
module fifo_wr_arb #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         fifo_full,
  output logic                         fifo_push,
  output logic [WIDTH-1:0]             fifo_data,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num
    $error("fifo_wr_arb: NUM_REQ out of range");
  end
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
    $error("fifo_wr_arb: MAX_BURST out of range");
  end

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + IW'(1);
  endfunction

  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] elig;
  logic               any_elig;
  logic [IW-1:0]      gnt;

  // First eligible index at or after rr_ptr, wrapping to 0.
  always_comb begin
    int idx;
    idx      = 0;
    any_elig = 1'b0;
    gnt      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!any_elig && elig[idx]) begin
        any_elig = 1'b1;
        gnt      = IW'(idx);
      end
    end
  end

  // Grant outputs; gated by rst_n so reset silences the FIFO at once.
  always_comb begin
    fifo_push = rst_n & any_elig & ~fifo_full;
    req_ready = '0;
    grant_id  = '0;
    fifo_data = '0;
    if (fifo_push) begin
      req_ready = NUM_REQ'(1) << gnt;
      grant_id  = gnt;
      fifo_data = req_data[int'(gnt)*WIDTH +: WIDTH];
    end
  end

`ifdef FIFO_WR_ARB_LOCK_EN

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [3:0]    cnt_q, cnt_d;

  // State register: pointer, lock state, owner and burst count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      state_q  <= IDLE;
      owner_q  <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state: take the lock on a push, drop it on full burst or owner idle.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (fifo_push) begin
          rr_ptr_d = wrap_inc(gnt);
          if (MAX_BURST > 1) begin
            state_d = LOCKED;
            owner_d = gnt;
            cnt_d   = 4'd1;
          end
        end
      end
      LOCKED: begin
        if (!req_valid[owner_q] ||
            (fifo_push && int'(cnt_q) + 1 >= MAX_BURST)) begin
          state_d  = IDLE;
          owner_d  = '0;
          cnt_d    = '0;
          rr_ptr_d = wrap_inc(owner_q);
        end else if (fifo_push) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Eligibility: only the owner may push while locked.
  always_comb begin
    elig = req_valid;
    if (state_q == LOCKED) begin
      elig = req_valid & (NUM_REQ'(1) << owner_q);
    end
  end

`else

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Advance past the grantee on each accepted push.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (fifo_push) begin
      rr_ptr_d = wrap_inc(gnt);
    end
  end

  // Every valid requester competes.
  always_comb begin
    elig = req_valid;
  end

`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: expected pushes queued at drive time,
// popped and compared against the combinational outputs each cycle.
module tb_fifo_wr_arb;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 3;
  localparam int EW = 1 + N + 2 + W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             fifo_full;
  logic             fifo_push;
  logic [W-1:0]     fifo_data;
  logic [1:0]       grant_id;

  logic [W-1:0]     dat [N];
  logic [EW-1:0]    exp_q [$];
  logic [EW-1:0]    obs, exp_w;
  int               checks = 0;
  int               failures = 0;

  always #5 clk = ~clk;

  assign req_data = {dat[3], dat[2], dat[1], dat[0]};

  fifo_wr_arb #(
    .NUM_REQ  (N),
    .WIDTH    (W),
    .MAX_BURST(MB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .fifo_full(fifo_full),
    .fifo_push(fifo_push),
    .fifo_data(fifo_data),
    .grant_id (grant_id)
  );

  function automatic logic [EW-1:0] mk(input logic p, input int g);
    logic [N-1:0] r;
    logic [1:0]   gi;
    logic [W-1:0] d;
    r  = p ? (N'(1) << g) : '0;
    gi = p ? 2'(g) : 2'd0;
    d  = p ? dat[g] : '0;
    return {p, r, gi, d};
  endfunction

  task automatic rand_data();
    for (int i = 0; i < N; i++) dat[i] = W'($urandom);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one cycle's inputs and queue the expected result.
  task automatic step(input logic [N-1:0] v, input logic f,
                      input logic p, input int g);
    @(negedge clk);
    req_valid = v;
    fifo_full = f;
    exp_q.push_back(mk(p, g));
    #1;
  endtask

  task automatic test_reset();
    rand_data();
    rst_n     = 1'b0;
    req_valid = '1;
    fifo_full = 1'b0;
    exp_q.push_back(mk(1'b0, 0));
    #1;
    obs   = {fifo_push, req_ready, grant_id, fifo_data};
    exp_w = exp_q.pop_front();
    checks++;
    if (obs !== exp_w) begin
      failures++;
      $display("FAIL reset_hold got=%h want=%h", obs, exp_w);
    end
    do_reset();
    step(4'b0000, 1'b0, 1'b0, 0);
    obs   = {fifo_push, req_ready, grant_id, fifo_data};
    exp_w = exp_q.pop_front();
    checks++;
    if (obs !== exp_w) begin
      failures++;
      $display("FAIL reset_idle got=%h want=%h", obs, exp_w);
    end
  endtask

  task automatic test_rr_all();
`ifdef FIFO_WR_ARB_LOCK_EN
    int g[5] = '{0, 0, 0, 1, 1};
`else
    int g[5] = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    rand_data();
    for (int c = 0; c < 5; c++) begin
      step(4'b1111, 1'b0, 1'b1, g[c]);
      obs   = {fifo_push, req_ready, grant_id, fifo_data};
      exp_w = exp_q.pop_front();
      checks++;
      if (obs !== exp_w) begin
        failures++;
        $display("FAIL rr_all c%0d got=%h want=%h", c, obs, exp_w);
      end
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    rand_data();
    dat[2] = 8'hA5;
    for (int c = 0; c < 4; c++) begin
      step(4'b0100, (c < 3), (c == 3), 2);
      obs   = {fifo_push, req_ready, grant_id, fifo_data};
      exp_w = exp_q.pop_front();
      checks++;
      if (obs !== exp_w) begin
        failures++;
        $display("FAIL full_stall c%0d got=%h want=%h", c, obs, exp_w);
      end
    end
  endtask

`ifndef FIFO_WR_ARB_LOCK_EN
  task automatic test_wrap();
    int g[4] = '{3, 0, 3, 0};
    do_reset();
    rand_data();
    step(4'b0100, 1'b0, 1'b1, 2);
    void'(exp_q.pop_front());
    for (int c = 0; c < 4; c++) begin
      step(4'b1001, 1'b0, 1'b1, g[c]);
      obs   = {fifo_push, req_ready, grant_id, fifo_data};
      exp_w = exp_q.pop_front();
      checks++;
      if (obs !== exp_w) begin
        failures++;
        $display("FAIL wrap c%0d got=%h want=%h", c, obs, exp_w);
      end
    end
  endtask
`else
  task automatic test_burst();
    int g[7] = '{0, 0, 0, 1, 1, 1, 0};
    do_reset();
    rand_data();
    for (int c = 0; c < 7; c++) begin
      step(4'b0011, 1'b0, 1'b1, g[c]);
      obs   = {fifo_push, req_ready, grant_id, fifo_data};
      exp_w = exp_q.pop_front();
      checks++;
      if (obs !== exp_w) begin
        failures++;
        $display("FAIL burst c%0d got=%h want=%h", c, obs, exp_w);
      end
    end
  endtask

  task automatic test_release();
    logic [N-1:0] v[5] = '{4'b0011, 4'b0010, 4'b0010, 4'b0101, 4'b0101};
    logic         p[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int           g[5] = '{0, 0, 1, 0, 2};
    do_reset();
    rand_data();
    for (int c = 0; c < 5; c++) begin
      step(v[c], 1'b0, p[c], g[c]);
      obs   = {fifo_push, req_ready, grant_id, fifo_data};
      exp_w = exp_q.pop_front();
      checks++;
      if (obs !== exp_w) begin
        failures++;
        $display("FAIL release c%0d got=%h want=%h", c, obs, exp_w);
      end
    end
  endtask
`endif

  task automatic test_mid_reset();
    do_reset();
    rand_data();
    for (int c = 0; c < 2; c++) begin
      step(4'b0100, 1'b0, 1'b1, 2);
      obs   = {fifo_push, req_ready, grant_id, fifo_data};
      exp_w = exp_q.pop_front();
      checks++;
      if (obs !== exp_w) begin
        failures++;
        $display("FAIL mid_pre c%0d got=%h want=%h", c, obs, exp_w);
      end
    end
    #2;
    rst_n = 1'b0;
    exp_q.push_back(mk(1'b0, 0));
    #1;
    obs   = {fifo_push, req_ready, grant_id, fifo_data};
    exp_w = exp_q.pop_front();
    checks++;
    if (obs !== exp_w) begin
      failures++;
      $display("FAIL mid_rst got=%h want=%h", obs, exp_w);
    end
    @(negedge clk);
    req_valid = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(mk(1'b1, 0));
    #1;
    obs   = {fifo_push, req_ready, grant_id, fifo_data};
    exp_w = exp_q.pop_front();
    checks++;
    if (obs !== exp_w) begin
      failures++;
      $display("FAIL mid_first got=%h want=%h", obs, exp_w);
    end
  endtask

  initial begin
    test_reset();
    test_rr_all();
    test_full_stall();
`ifndef FIFO_WR_ARB_LOCK_EN
    test_wrap();
`else
    test_burst();
    test_release();
`endif
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, data width matching the FIFO data_in.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum pushes per lock tenure (1..15).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester push request.
REQ-007 SHALL have port req_data  input  NUM_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_ready  output  NUM_REQ  one-hot accept; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL have port fifo_full  input  1  FIFO mem_full.
REQ-010 SHALL have port fifo_push  output  1  FIFO push strobe.
REQ-011 SHALL have port fifo_data  output  WIDTH  FIFO data_in.
REQ-012 SHALL have port grant_id  output  $clog2(NUM_REQ)  index of the current grantee, 0 when no grant.

Function
REQ-013 SHALL derive grant combinationally: fifo_push = (any eligible req_valid) & !fifo_full, with zero-cycle latency from request to push.
REQ-014 SHALL keep req_ready all-zero while fifo_full=1; fifo_push SHALL never assert while fifo_full=1.
REQ-015 SHALL drive fifo_data = req_data of the grantee when fifo_push=1, and all-zero otherwise.
REQ-016 SHALL select round-robin: search starts at register rr_ptr and wraps from NUM_REQ-1 to 0; the first valid index wins.
REQ-017 SHALL, on each accepted push in unlocked operation, load rr_ptr with (grantee+1) mod NUM_REQ; rr_ptr SHALL otherwise hold.
REQ-018 SHALL leave req_ready[i] low for every i not granted, including requesters that are valid but lose arbitration.
REQ-019 SHALL keep req_ready asserted only while the requester keeps req_valid high; de-asserting req_valid without a transfer is legal and causes no state change.

Reset
REQ-020 SHALL, while rst_n=0, force rr_ptr=0, lock state IDLE, burst count 0, fifo_push=0, req_ready=0, fifo_data=0 and grant_id=0.
REQ-021 SHALL apply reset asynchronously, including mid-burst; the first grant after release SHALL search from index 0.

Configuration
REQ-022 SHALL compile burst locking in when FIFO_WR_ARB_LOCK_EN is defined; without the macro, behaviour SHALL be pure round-robin per REQ-016/017, with no lock registers.
REQ-023 SHALL, with the macro defined, use states IDLE and LOCKED: an accepted push in IDLE by requester i SHALL enter LOCKED with owner=i and count=1, unless MAX_BURST=1.
REQ-024 SHALL, in LOCKED, make only the owner eligible; each accepted push SHALL increment count; a fifo_full stall SHALL hold both count and lock.
REQ-025 SHALL exit LOCKED to IDLE on the push that makes count==MAX_BURST, or in any cycle in which req_valid[owner]=0; on exit, rr_ptr SHALL be set to (owner+1) mod NUM_REQ and count SHALL be cleared.

Verification
REQ-026 SHALL cover this case, with the macro undefined, NUM_REQ=4: all req_valid=1 and fifo_full=0 for 5 cycles -> grant_id 0,1,2,3,0, with fifo_data equal to the respective req_data each cycle.
REQ-027 SHALL cover this case: only req_valid[2]=1 with data 0xA5, and fifo_full=1 for 3 cycles then 0 -> fifo_push=0 and req_ready=0 for 3 cycles, then fifo_push=1 with fifo_data=0xA5 on cycle 4.
REQ-028 SHALL cover this case: only req_valid[3] and req_valid[0] held high, rr_ptr=3 -> grants 3,0,3,0 (wrap-around).
REQ-029 SHALL cover this case, with the macro defined and MAX_BURST=3: req_valid[0] and req_valid[1] held high -> grants 0,0,0,1,1,1,0.
REQ-030 SHALL cover this case, with the macro defined: req_valid[0] drops after 1 push while req_valid[1]=1 -> lock released, next push granted to 1, and rr_ptr then equals 2.
REQ-031 SHALL cover this case: rst_n pulsed low mid-burst with owner=2 -> fifo_push=0 immediately; after release with all requesters valid -> first grant_id=0.
